alu_issue_stage: RTL and testbench

Two-entry elastic pipeline that sits directly upstream of the combinational `alu` and captures its results. It accepts decoded RV64I integer ops from the decoder and conditions the operands: W-form masking and extension, shift-amount limiting, and SUB and compare setup. It drives the ALU enables, then post-processes the ALU output (SLT/SLTU from flags, ADDW/SUBW sign-extension) into a registered result with flags. Throughput is one op per cycle with valid/ready backpressure on both sides.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_op_decode.sv | 86 ++++++++
 rtl/alu_issue_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code enum, flag bit positions and a sign-extension helper.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } aluop_t;

  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps the S1 op into ALU operands, carry-in and enables, plus result post-processing selects.
// W-form conditioning is built only when ALU_ISSUE_W_OPS_EN is defined.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            valid_i,
  input  logic [3:0]      op_i,
  input  logic            w_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic            alu_cflag_o,
  output logic            sum_en_o,
  output logic            and_en_o,
  output logic            xor_en_o,
  output logic            invb_en_o,
  output logic            lsh_en_o,
  output logic            rsh_en_o,
  output logic            err_o,
  output logic            slt_o,
  output logic            sltu_o,
  output logic            wsext_o
);

  logic w_ok;
  logic is_shift;

  // Operand conditioning and enable decode.
  always_comb begin
    alu_a_o     = a_i;
    alu_b_o     = b_i;
    alu_cflag_o = 1'b0;
    sum_en_o    = 1'b0;
    and_en_o    = 1'b0;
    xor_en_o    = 1'b0;
    invb_en_o   = 1'b0;
    lsh_en_o    = 1'b0;
    rsh_en_o    = 1'b0;
    slt_o       = 1'b0;
    sltu_o      = 1'b0;
    wsext_o     = 1'b0;
    is_shift    = (op_i == SLL) || (op_i == SRL) || (op_i == SRA);
`ifdef ALU_ISSUE_W_OPS_EN
    w_ok = (op_i == ADD) || (op_i == SUB) || is_shift;
`else
    w_ok = 1'b0;
`endif
    err_o = (op_i > 4'd9) || (w_i && !w_ok);

    if (valid_i && !err_o) begin
      case (op_i)
        ADD:  sum_en_o = 1'b1;
        SUB:  begin sum_en_o = 1'b1; invb_en_o = 1'b1; alu_cflag_o = 1'b1; end
        AND:  and_en_o = 1'b1;
        OR:   begin and_en_o = 1'b1; xor_en_o = 1'b1; end
        XOR:  xor_en_o = 1'b1;
        SLL:  lsh_en_o = 1'b1;
        SRL:  rsh_en_o = 1'b1;
        SRA:  begin rsh_en_o = 1'b1; alu_cflag_o = 1'b1; end
        SLT:  begin sum_en_o = 1'b1; invb_en_o = 1'b1; alu_cflag_o = 1'b1; slt_o = 1'b1; end
        SLTU: begin sum_en_o = 1'b1; invb_en_o = 1'b1; alu_cflag_o = 1'b1; sltu_o = 1'b1; end
        default: ;
      endcase
    end else begin
      alu_cflag_o = 1'b0;
    end

`ifdef ALU_ISSUE_W_OPS_EN
    // 32-bit shifts use a 5-bit amount and a 32-bit source extended to 64 bits.
    if (w_i && w_ok) begin
      wsext_o = 1'b1;
      if (is_shift) alu_b_o[5] = 1'b0;
      else          alu_b_o    = b_i;
      if (op_i == SRL)      alu_a_o = {32'd0, a_i[31:0]};
      else if (op_i == SRA) alu_a_o = sext32(a_i[31:0]);
      else                  alu_a_o = a_i;
    end else begin
      wsext_o = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry elastic stage around the external ALU: S1 holds the op, S2 the post-processed result.
// Optional W-form support is enabled by defining ALU_ISSUE_W_OPS_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      in_op_i,
  input  logic            in_w_i,
  input  logic [XLEN-1:0] in_a_i,
  input  logic [XLEN-1:0] in_b_i,
  input  logic [4:0]      in_tag_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic            alu_cflag_o,
  output logic            alu_sum_en_o,
  output logic            alu_and_en_o,
  output logic            alu_xor_en_o,
  output logic            alu_invB_en_o,
  output logic            alu_lsh_en_o,
  output logic            alu_rsh_en_o,
  input  logic [XLEN-1:0] alu_out_i,
  input  logic            alu_cflag_i,
  input  logic            alu_vflag_i,
  input  logic            alu_zflag_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_data_o,
  output logic [4:0]      res_tag_o,
  output logic [2:0]      res_flags_o,
  output logic            res_err_o
);

  logic            s1_valid_q, s1_valid_d;
  logic [3:0]      s1_op_q, s1_op_d;
  logic            s1_w_q, s1_w_d;
  logic [XLEN-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [4:0]      s1_tag_q, s1_tag_d;
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_data_q, s2_data_d;
  logic [4:0]      s2_tag_q, s2_tag_d;
  logic [2:0]      s2_flags_q, s2_flags_d;
  logic            s2_err_q, s2_err_d;

  logic            s2_adv;
  logic            dec_err, dec_slt, dec_sltu, dec_wsext;
  logic [XLEN-1:0] res_s;
  logic [2:0]      flags_s;

  assign s2_adv     = !s2_valid_q || res_ready_i;
  assign in_ready_o = !s1_valid_q || s2_adv;

  alu_op_decode #(.XLEN(XLEN)) u_dec (
    .valid_i     (s1_valid_q),
    .op_i        (s1_op_q),
    .w_i         (s1_w_q),
    .a_i         (s1_a_q),
    .b_i         (s1_b_q),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_cflag_o (alu_cflag_o),
    .sum_en_o    (alu_sum_en_o),
    .and_en_o    (alu_and_en_o),
    .xor_en_o    (alu_xor_en_o),
    .invb_en_o   (alu_invB_en_o),
    .lsh_en_o    (alu_lsh_en_o),
    .rsh_en_o    (alu_rsh_en_o),
    .err_o       (dec_err),
    .slt_o       (dec_slt),
    .sltu_o      (dec_sltu),
    .wsext_o     (dec_wsext)
  );

  // Result post-processing; flags are taken raw from the ALU.
  always_comb begin
    flags_s         = 3'd0;
    flags_s[FLAG_C] = alu_cflag_i;
    flags_s[FLAG_V] = alu_vflag_i;
    flags_s[FLAG_Z] = alu_zflag_i;
    if (dec_err)        res_s = {XLEN{1'b0}};
    else if (dec_slt)   res_s = {{(XLEN-1){1'b0}}, alu_out_i[XLEN-1] ^ alu_vflag_i};
    else if (dec_sltu)  res_s = {{(XLEN-1){1'b0}}, !alu_cflag_i};
    else if (dec_wsext) res_s = sext32(alu_out_i[31:0]);
    else                res_s = alu_out_i;
  end

  // Next-state for both pipeline registers; S1 may refill on the edge it drains.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_w_d     = s1_w_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_flags_d = s2_flags_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d  = res_s;
        s2_tag_d   = s1_tag_q;
        s2_flags_d = flags_s;
        s2_err_d   = dec_err;
      end else begin
        s2_err_d   = s2_err_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (in_valid_i && in_ready_o) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op_i;
      s1_w_d     = in_w_i;
      s1_a_d     = in_a_i;
      s1_b_d     = in_b_i;
      s1_tag_d   = in_tag_i;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 4'd0;
      s1_w_q     <= 1'b0;
      s1_a_q     <= {XLEN{1'b0}};
      s1_b_q     <= {XLEN{1'b0}};
      s1_tag_q   <= 5'd0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= {XLEN{1'b0}};
      s2_tag_q   <= 5'd0;
      s2_flags_q <= 3'd0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_w_q     <= s1_w_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_flags_q <= s2_flags_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign res_valid_o = s2_valid_q;
  assign res_data_o  = s2_data_q;
  assign res_tag_o   = s2_tag_q;
  assign res_flags_o = s2_flags_q;
  assign res_err_o   = s2_err_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, directed vector table, stall/reset sequences and
// randomized traffic checked against a specification-level reference model.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_W_OPS_EN
  localparam bit W_EN = 1'b1;
`else
  localparam bit W_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        in_valid_i, in_ready_o, in_w_i;
  logic [3:0]  in_op_i;
  logic [63:0] in_a_i, in_b_i;
  logic [4:0]  in_tag_i;
  logic [63:0] alu_a_o, alu_b_o;
  logic        alu_cflag_o, alu_sum_en_o, alu_and_en_o, alu_xor_en_o;
  logic        alu_invB_en_o, alu_lsh_en_o, alu_rsh_en_o;
  logic [63:0] alu_out_i;
  logic        alu_cflag_i, alu_vflag_i, alu_zflag_i;
  logic        res_valid_o, res_ready_i, res_err_o;
  logic [63:0] res_data_o;
  logic [4:0]  res_tag_o;
  logic [2:0]  res_flags_o;

  always #5 clk_i = ~clk_i;

  alu_issue_stage #(.XLEN(64)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i), .in_w_i(in_w_i),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_tag_i(in_tag_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_cflag_o(alu_cflag_o),
    .alu_sum_en_o(alu_sum_en_o), .alu_and_en_o(alu_and_en_o), .alu_xor_en_o(alu_xor_en_o),
    .alu_invB_en_o(alu_invB_en_o), .alu_lsh_en_o(alu_lsh_en_o), .alu_rsh_en_o(alu_rsh_en_o),
    .alu_out_i(alu_out_i), .alu_cflag_i(alu_cflag_i), .alu_vflag_i(alu_vflag_i),
    .alu_zflag_i(alu_zflag_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_tag_o(res_tag_o), .res_flags_o(res_flags_o), .res_err_o(res_err_o)
  );

  // Behavioural stand-in for the external combinational ALU.
  logic [63:0] bx;
  logic [64:0] s65;
  logic signed [63:0] sra_v;
  always_comb begin
    bx    = alu_invB_en_o ? ~alu_b_o : alu_b_o;
    s65   = {1'b0, alu_a_o} + {1'b0, bx} + {64'd0, alu_cflag_o};
    sra_v = $signed(alu_a_o) >>> alu_b_o[5:0];
    alu_out_i = 64'd0;
    if (alu_sum_en_o) alu_out_i = alu_out_i | s65[63:0];
    if (alu_and_en_o) alu_out_i = alu_out_i | (alu_a_o & alu_b_o);
    if (alu_xor_en_o) alu_out_i = alu_out_i | (alu_a_o ^ alu_b_o);
    if (alu_lsh_en_o) alu_out_i = alu_out_i | (alu_a_o << alu_b_o[5:0]);
    if (alu_rsh_en_o) alu_out_i = alu_out_i | (alu_cflag_o ? sra_v : (alu_a_o >> alu_b_o[5:0]));
    alu_cflag_i = alu_sum_en_o & s65[64];
    alu_vflag_i = alu_sum_en_o & (alu_a_o[63] == bx[63]) & (s65[63] != alu_a_o[63]);
    alu_zflag_i = (alu_out_i == 64'd0);
  end

  typedef struct {
    logic [4:0]  tag;
    logic [63:0] data;
    logic        err;
    logic [2:0]  flags;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_data;
    logic        exp_err;
    logic        chk_f;
    logic [2:0]  exp_f;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  bit   hold_prev = 1'b0;
  logic [63:0] prev_a, prev_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: RV64I semantics of the op, plus the flags an enabled ALU reports for it.
  function automatic exp_t model(input logic [3:0] op, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] tag);
    exp_t e;
    logic [63:0] ea, r;
    logic [64:0] t;
    logic [5:0]  sh;
    logic signed [63:0] sr;
    logic c, v;
    e.tag = tag;
    e.err = (op > 4'd9) || (w && !(W_EN && (op == 4'd0 || op == 4'd1 || op == 4'd5 ||
                                             op == 4'd6 || op == 4'd7)));
    if (e.err) begin
      e.data = 64'd0; e.flags = 3'b001;  // idle ALU reads as zero
      return e;
    end
    ea = a; sh = b[5:0]; c = 1'b0; v = 1'b0; r = 64'd0;
    if (w) begin
      sh[5] = 1'b0;
      if (op == 4'd6) ea = {32'd0, a[31:0]};
      if (op == 4'd7) ea = {{32{a[31]}}, a[31:0]};
    end
    case (op)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[63:0]; c = t[64];
                  v = (a[63] == b[63]) && (r[63] != a[63]); end
      4'd1, 4'd8, 4'd9: begin r = a - b; c = (a >= b);
                  v = (a[63] != b[63]) && (r[63] != a[63]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ea << sh;
      4'd6: r = ea >> sh;
      4'd7: begin sr = $signed(ea) >>> sh; r = sr; end
      default: r = 64'd0;
    endcase
    e.flags = {c, v, (r == 64'd0)};
    if (op == 4'd8)      e.data = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
    else if (op == 4'd9) e.data = (a < b) ? 64'd1 : 64'd0;
    else if (w)          e.data = {{32{r[31]}}, r[31:0]};
    else                 e.data = r;
    return e;
  endfunction

  // One cycle of scoreboard-checked traffic; called at a negedge with inputs already driven.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    if (hold_prev) begin
      chk("stall_hold_a", alu_a_o, prev_a);
      chk("stall_hold_b", alu_b_o, prev_b);
    end
    if (res_valid_o && res_ready_i) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra: got result tag %0d, expected no result", res_tag_o);
      end else begin
        e = sb.pop_front();
        chk("sb_tag",   {59'd0, res_tag_o},   {59'd0, e.tag});
        chk("sb_data",  res_data_o,           e.data);
        chk("sb_err",   {63'd0, res_err_o},   {63'd0, e.err});
        chk("sb_flags", {61'd0, res_flags_o}, {61'd0, e.flags});
      end
    end
    acc = in_valid_i && in_ready_o;
    if (acc) sb.push_back(model(in_op_i, in_w_i, in_a_i, in_b_i, in_tag_i));
    hold_prev = !in_ready_o;
    prev_a = alu_a_o; prev_b = alu_b_o;
    @(negedge clk_i);
  endtask

  // Single op through an idle pipe, checking the two-edge latency.
  task automatic run_one(input logic [3:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, output exp_t got);
    in_op_i = op; in_w_i = w; in_a_i = a; in_b_i = b; in_tag_i = tag;
    in_valid_i = 1'b1; res_ready_i = 1'b1;
    #1 chk("ready_idle", {63'd0, in_ready_o}, 64'd1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1 chk("lat_edge1", {63'd0, res_valid_o}, 64'd0);
    @(negedge clk_i);
    #1 chk("lat_edge2", {63'd0, res_valid_o}, 64'd1);
    got.tag = res_tag_o; got.data = res_data_o; got.err = res_err_o; got.flags = res_flags_o;
    @(negedge clk_i);
  endtask

  vec_t vecs[14];
  exp_t got;
  bit   acc;
  int   n_in, n_cyc;
  bit   saw_not_ready;

  initial begin
    vecs[0]  = '{4'd1, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 3'b000};
    vecs[1]  = '{4'd8, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 1'b0, 1'b0, 3'b000};
    vecs[2]  = '{4'd9, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b0, 1'b0, 3'b000};
    vecs[3]  = '{4'd7, 1'b1, 64'h0000_0000_8000_0000, 64'h21,
                 W_EN ? 64'hFFFF_FFFF_C000_0000 : 64'd0, !W_EN, 1'b0, 3'b000};
    vecs[4]  = '{4'd3, 1'b0, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 3'b000};
    vecs[5]  = '{4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1,
                 W_EN ? 64'hFFFF_FFFF_8000_0000 : 64'd0, !W_EN, 1'b0, 3'b000};
    vecs[6]  = '{4'd12, 1'b0, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1, 3'b001};
    vecs[7]  = '{4'd0, 1'b0, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 3'b000};
    vecs[8]  = '{4'd4, 1'b0, 64'hFF, 64'h0F, 64'hF0, 1'b0, 1'b0, 3'b000};
    vecs[9]  = '{4'd5, 1'b0, 64'd1, 64'h43, 64'd8, 1'b0, 1'b0, 3'b000};
    vecs[10] = '{4'd7, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 1'b0, 3'b000};
    vecs[11] = '{4'd6, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 1'b0, 3'b000};
    vecs[12] = '{4'd2, 1'b1, 64'hFF, 64'hFF, 64'd0, 1'b1, 1'b0, 3'b000};
    vecs[13] = '{4'd15, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b000};

    reset_i = 1'b1; in_valid_i = 1'b0; in_op_i = 4'd0; in_w_i = 1'b0;
    in_a_i = 64'd0; in_b_i = 64'd0; in_tag_i = 5'd0; res_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("rst_res_valid", {63'd0, res_valid_o}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready_o},  64'd1);
    chk("rst_data",      res_data_o, 64'd0);
    @(negedge clk_i);

    for (int i = 0; i < 14; i++) begin
      run_one(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, 5'(i), got);
      chk($sformatf("vec%0d_data", i), got.data, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {63'd0, got.err}, {63'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_tag", i), {59'd0, got.tag}, 64'(i));
      if (vecs[i].chk_f) chk($sformatf("vec%0d_flags", i), {61'd0, got.flags}, {61'd0, vecs[i].exp_f});
    end

    // Stream of 8 ADDs with the consumer stalled for cycles 3..5.
    n_in = 0; saw_not_ready = 1'b0; hold_prev = 1'b0;
    for (n_cyc = 0; n_cyc < 60; n_cyc++) begin
      if (n_in == 8 && sb.size() == 0 && !res_valid_o) break;
      in_valid_i = (n_in < 8); in_op_i = 4'd0; in_w_i = 1'b0;
      in_a_i = {$urandom, $urandom}; in_b_i = {$urandom, $urandom}; in_tag_i = 5'(n_in + 8);
      res_ready_i = !(n_cyc >= 3 && n_cyc <= 5);
      #0 if (!in_ready_o) saw_not_ready = 1'b1;
      cycle(acc);
      if (acc) n_in++;
    end
    chk("stream_all_in", 64'(n_in), 64'd8);
    chk("stream_drained", 64'(sb.size()), 64'd0);
    chk("stream_backpressure", {63'd0, saw_not_ready}, 64'd1);

    // Reset with both stages full.
    res_ready_i = 1'b0; in_valid_i = 1'b1; in_op_i = 4'd1; hold_prev = 1'b0;
    in_tag_i = 5'd1; cycle(acc);
    in_tag_i = 5'd2; cycle(acc);
    in_valid_i = 1'b0; reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0; sb.delete(); hold_prev = 1'b0;
    #1;
    chk("rst2_res_valid", {63'd0, res_valid_o}, 64'd0);
    chk("rst2_err",       {63'd0, res_err_o},   64'd0);
    chk("rst2_tag_flags", {56'd0, res_tag_o, res_flags_o}, 64'd0);
    chk("rst2_enables", {58'd0, alu_sum_en_o, alu_and_en_o, alu_xor_en_o,
                         alu_invB_en_o, alu_lsh_en_o, alu_rsh_en_o}, 64'd0);
    chk("rst2_in_ready", {63'd0, in_ready_o}, 64'd1);
    @(negedge clk_i);
    run_one(4'd0, 1'b0, 64'd40, 64'd2, 5'd9, got);
    chk("post_rst_data", got.data, 64'd42);

    // Randomized traffic against the reference model.
    hold_prev = 1'b0;
    for (int k = 0; k < 400; k++) begin
      in_valid_i  = ($urandom_range(3) != 0);
      in_op_i     = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
      in_w_i      = ($urandom_range(3) == 0);
      in_a_i      = ($urandom_range(5) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      in_b_i      = ($urandom_range(2) == 0) ? 64'($urandom_range(127)) : {$urandom, $urandom};
      in_tag_i    = 5'($urandom);
      res_ready_i = ($urandom_range(3) != 0);
      cycle(acc);
    end
    in_valid_i = 1'b0; res_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) cycle(acc);
    chk("rand_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
